// File: rtl/fetch_decode_ctrl.sv
// Pipeline front end: PC register, ARM-subset decoder, bubble mux.
// Optional PC_TARGET_EN adds pc_load/target_pc direct PC load.
module fetch_decode_ctrl #(
  parameter int PC_WIDTH = 8,
  parameter int PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                E,
  input  logic                S,
`ifdef PC_TARGET_EN
  input  logic                pc_load,
  input  logic [PC_WIDTH-1:0] target_pc,
`endif
  input  logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic [3:0]          dec_alu_op,
  output logic [1:0]          dec_am,
  output logic                dec_load,
  output logic                dec_mem_write,
  output logic                dec_store_cc,
  output logic                dec_b,
  output logic                dec_bl,
  output logic                dec_mem_size,
  output logic                dec_mem_e,
  output logic                dec_rf_e,
  output logic [3:0]          ctl_alu_op,
  output logic [1:0]          ctl_am,
  output logic                ctl_load,
  output logic                ctl_mem_write,
  output logic                ctl_store_cc,
  output logic                ctl_b,
  output logic                ctl_bl,
  output logic                ctl_mem_size,
  output logic                ctl_mem_e,
  output logic                ctl_rf_e
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (!reset) begin
      pc_d = '0;
    end else if (E) begin
      pc_d = pc_q + PC_WIDTH'(PC_STEP);
`ifdef PC_TARGET_EN
      if (pc_load) pc_d = target_pc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  assign pc = pc_q;

  logic [2:0] cls;
  logic       is_nop;
  logic       is_dp;
  logic       is_ls;
  logic       is_br;

  assign cls    = instruction[27:25];
  assign is_nop = (instruction == 32'h0);
  assign is_dp  = !is_nop && (cls[2:1] == 2'b00);
  assign is_ls  = !is_nop && (cls[2:1] == 2'b01);
  assign is_br  = !is_nop && (cls == 3'b101);

  always_comb begin
    dec_alu_op    = 4'b0000;
    dec_am        = 2'b00;
    dec_load      = 1'b0;
    dec_mem_write = 1'b0;
    dec_store_cc  = 1'b0;
    dec_b         = 1'b0;
    dec_bl        = 1'b0;
    dec_mem_size  = 1'b0;
    dec_mem_e     = 1'b0;
    dec_rf_e      = 1'b0;
    unique case (1'b1)
      is_dp: begin
        dec_alu_op   = instruction[24:21];
        dec_am       = cls[0] ? 2'b00 : 2'b01;
        dec_store_cc = instruction[20];
        dec_rf_e     = 1'b1;
        // compare/test ops only set flags
        if (instruction[24:23] == 2'b10) begin
          dec_rf_e     = 1'b0;
          dec_store_cc = 1'b1;
        end
      end
      is_ls: begin
        dec_am        = cls[0] ? 2'b11 : 2'b10;
        dec_alu_op    = instruction[23] ? 4'b0100
                                        : 4'b0010;
        dec_mem_e     = 1'b1;
        dec_load      = instruction[20];
        dec_mem_write = ~instruction[20];
        dec_rf_e      = instruction[20];
        dec_mem_size  = instruction[22];
      end
      is_br: begin
        dec_b    = 1'b1;
        dec_bl   = instruction[24];
        dec_rf_e = instruction[24];
      end
      default: ;
    endcase
  end

  assign ctl_alu_op    = S ? 4'b0000 : dec_alu_op;
  assign ctl_am        = S ? 2'b00   : dec_am;
  assign ctl_load      = S ? 1'b0    : dec_load;
  assign ctl_mem_write = S ? 1'b0    : dec_mem_write;
  assign ctl_store_cc  = S ? 1'b0    : dec_store_cc;
  assign ctl_b         = S ? 1'b0    : dec_b;
  assign ctl_bl        = S ? 1'b0    : dec_bl;
  assign ctl_mem_size  = S ? 1'b0    : dec_mem_size;
  assign ctl_mem_e     = S ? 1'b0    : dec_mem_e;
  assign ctl_rf_e      = S ? 1'b0    : dec_rf_e;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: PC sequencing, decode, bubble mux.
// Define PC_TARGET_EN to also exercise the direct PC load.
module tb_fetch_decode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        E;
  logic        S;
  logic [31:0] instruction;
  logic [7:0]  pc;
`ifdef PC_TARGET_EN
  logic        pc_load;
  logic [7:0]  target_pc;
`endif
  logic [3:0]  dec_alu_op, ctl_alu_op;
  logic [1:0]  dec_am, ctl_am;
  logic        dec_load, dec_mem_write, dec_store_cc;
  logic        dec_b, dec_bl, dec_mem_size;
  logic        dec_mem_e, dec_rf_e;
  logic        ctl_load, ctl_mem_write, ctl_store_cc;
  logic        ctl_b, ctl_bl, ctl_mem_size;
  logic        ctl_mem_e, ctl_rf_e;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_decode_ctrl dut (
    .clk(clk), .reset(reset), .E(E), .S(S),
`ifdef PC_TARGET_EN
    .pc_load(pc_load), .target_pc(target_pc),
`endif
    .instruction(instruction), .pc(pc),
    .dec_alu_op(dec_alu_op), .dec_am(dec_am),
    .dec_load(dec_load),
    .dec_mem_write(dec_mem_write),
    .dec_store_cc(dec_store_cc),
    .dec_b(dec_b), .dec_bl(dec_bl),
    .dec_mem_size(dec_mem_size),
    .dec_mem_e(dec_mem_e), .dec_rf_e(dec_rf_e),
    .ctl_alu_op(ctl_alu_op), .ctl_am(ctl_am),
    .ctl_load(ctl_load),
    .ctl_mem_write(ctl_mem_write),
    .ctl_store_cc(ctl_store_cc),
    .ctl_b(ctl_b), .ctl_bl(ctl_bl),
    .ctl_mem_size(ctl_mem_size),
    .ctl_mem_e(ctl_mem_e), .ctl_rf_e(ctl_rf_e)
  );

  // {alu_op, am, load, mem_write, store_cc, b, bl, mem_size, mem_e, rf_e}
  function automatic logic [13:0] mk(
    input logic [3:0] alu, input logic [1:0] am,
    input logic ld, input logic mw, input logic scc,
    input logic b, input logic bl, input logic ms,
    input logic me, input logic rf);
    return {alu, am, ld, mw, scc, b, bl, ms, me, rf};
  endfunction

  logic [13:0] dec_v, ctl_v;
  assign dec_v = {dec_alu_op, dec_am, dec_load,
                  dec_mem_write, dec_store_cc, dec_b,
                  dec_bl, dec_mem_size, dec_mem_e,
                  dec_rf_e};
  assign ctl_v = {ctl_alu_op, ctl_am, ctl_load,
                  ctl_mem_write, ctl_store_cc, ctl_b,
                  ctl_bl, ctl_mem_size, ctl_mem_e,
                  ctl_rf_e};

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(input logic [31:0] ins,
                      input logic [13:0] exp);
    instruction = ins;
    S = 1'b0;
    #1;
    chk($sformatf("dec %h S0", ins), 32'(dec_v), 32'(exp));
    chk($sformatf("ctl %h S0", ins), 32'(ctl_v), 32'(exp));
    S = 1'b1;
    #1;
    chk($sformatf("dec %h S1", ins), 32'(dec_v), 32'(exp));
    chk($sformatf("ctl %h S1", ins), 32'(ctl_v), 32'd0);
    S = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    E = 1'b0;
    S = 1'b0;
    instruction = 32'h0;
`ifdef PC_TARGET_EN
    pc_load = 1'b0;
    target_pc = 8'd0;
`endif
    step();
    chk("pc reset", 32'(pc), 32'd0);
    reset = 1'b1;
    E = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("pc inc %0d", i), 32'(pc), 32'(4 * i));
    end
    E = 1'b0;
    step();
    chk("pc hold 1", 32'(pc), 32'd16);
    step();
    chk("pc hold 2", 32'(pc), 32'd16);
    E = 1'b1;
    for (int i = 0; i < 59; i++) step();
    chk("pc 252", 32'(pc), 32'd252);
    step();
    chk("pc wrap", 32'(pc), 32'd0);
    step();
    step();
    chk("pc 8", 32'(pc), 32'd8);
    reset = 1'b0;
    step();
    chk("pc reset over E", 32'(pc), 32'd0);
    reset = 1'b1;
`ifdef PC_TARGET_EN
    pc_load = 1'b1;
    target_pc = 8'd40;
    step();
    chk("pc load", 32'(pc), 32'd40);
    E = 1'b0;
    target_pc = 8'd100;
    step();
    chk("pc load no E", 32'(pc), 32'd40);
    E = 1'b1;
    reset = 1'b0;
    step();
    chk("pc reset over load", 32'(pc), 32'd0);
    reset = 1'b1;
    pc_load = 1'b0;
`endif
    E = 1'b0;

    dchk(32'hE0805183, mk(4'b0100, 2'b01,
         0, 0, 0, 0, 0, 0, 0, 1));
    dchk(32'hE3110000, mk(4'b1000, 2'b00,
         0, 0, 1, 0, 0, 0, 0, 0));
    dchk(32'hE2110000, mk(4'b0000, 2'b00,
         0, 0, 1, 0, 0, 0, 0, 1));
    dchk(32'hE1500001, mk(4'b1010, 2'b01,
         0, 0, 1, 0, 0, 0, 0, 0));
    dchk(32'h00000001, mk(4'b0000, 2'b01,
         0, 0, 0, 0, 0, 0, 0, 1));
    dchk(32'hE7D12000, mk(4'b0100, 2'b11,
         1, 0, 0, 0, 0, 1, 1, 1));
    dchk(32'hE58A5000, mk(4'b0100, 2'b10,
         0, 1, 0, 0, 0, 0, 1, 0));
    dchk(32'hE5000000, mk(4'b0010, 2'b10,
         0, 1, 0, 0, 0, 0, 1, 0));
    dchk(32'h1AFFFFFD, mk(4'b0000, 2'b00,
         0, 0, 0, 1, 0, 0, 0, 0));
    dchk(32'hDB000009, mk(4'b0000, 2'b00,
         0, 0, 0, 1, 1, 0, 0, 1));
    dchk(32'h00000000, 14'd0);
    dchk(32'hE8000000, 14'd0);
    dchk(32'hEC000000, 14'd0);
    dchk(32'hEE000000, 14'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
